// File: rtl/fczlib_metering_event_gen.sv
// fczlib_metering_event_gen
// Collects per-CU job-completion pulses into a saturating pending counter and
// replays them to the DRM activator as single-cycle metering_event pulses,
// each followed by at least EVENT_GAP idle cycles. Also registers the
// activator's activation_code into per-CU run enables.
//
// Build option: FCZLIB_METER_ACT_GATE_EN
//   defined   - completions are counted only for CUs whose cu_enable bit is set;
//               cu_enable follows activation_code[NUM_CU-1:0] one cycle later.
//   undefined - every completion is counted; cu_enable becomes all ones on the
//               first clock after reset release; activation_code is ignored.
module fczlib_metering_event_gen #(
    parameter int NUM_CU    = 4,
    parameter int CNT_W     = 16,
    parameter int EVENT_GAP = 2
) (
    input  logic              ip_core_aclk,
    input  logic              ip_core_arstn,
    input  logic [NUM_CU-1:0] cu_job_done,
    input  logic [127:0]      activation_code,
    input  logic              clear_overflow,
    output logic              metering_event,
    output logic [NUM_CU-1:0] cu_enable,
    output logic [CNT_W-1:0]  pending_count,
    output logic              overflow
);

    // Four spare bits hold pending + up to 8 completions without wrapping.
    localparam int SUM_W = CNT_W + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};
    localparam int GAP_W = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(EVENT_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                event_q, event_d;
    logic [CNT_W-1:0]    pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [NUM_CU-1:0]   cu_enable_q, cu_enable_d;

    logic [NUM_CU-1:0]   gate_mask;
    logic [NUM_CU-1:0]   accepted;
    logic [SUM_W-1:0]    inc;
    logic                dec;
    logic [SUM_W-1:0]    sum;

    // Only the low NUM_CU bits ever matter, and none of them without the gate.
    logic                unused_act;
    assign unused_act = ^activation_code;

`ifdef FCZLIB_METER_ACT_GATE_EN
    assign gate_mask   = cu_enable_q;
    assign cu_enable_d = activation_code[NUM_CU-1:0];
`else
    assign gate_mask   = {NUM_CU{1'b1}};
    assign cu_enable_d = {NUM_CU{1'b1}};
`endif

    // Per-CU accepted completion: the raw pulse qualified by the gate.
    generate
        for (genvar gi = 0; gi < NUM_CU; gi++) begin : g_accept
            assign accepted[gi] = cu_job_done[gi] & gate_mask[gi];
        end
    endgenerate

    // Popcount of accepted completions this cycle.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CU; i++) begin
            inc = inc + {{(SUM_W-1){1'b0}}, accepted[i]};
        end
    end

    // Event FSM next state; dec is raised on the IDLE->PULSE transition only,
    // so it never fires while pending is zero and the sum cannot underflow.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        event_d   = 1'b0;
        dec       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d = PULSE;
                    event_d = 1'b1;
                    dec     = 1'b1;
                end
            end
            PULSE: begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating pending counter; a new overflow outranks a same-cycle clear.
    always_comb begin
        sum        = {4'b0000, pending_q} + inc - {{(SUM_W-1){1'b0}}, dec};
        pending_d  = sum[CNT_W-1:0];
        overflow_d = overflow_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (sum > CNT_MAX) begin
            pending_d  = {CNT_W{1'b1}};
            overflow_d = 1'b1;
        end
    end

    // All state flops, cleared asynchronously so a reset drops the backlog.
    always_ff @(posedge ip_core_aclk or negedge ip_core_arstn) begin
        if (!ip_core_arstn) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            event_q     <= 1'b0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            cu_enable_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            event_q     <= event_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            cu_enable_q <= cu_enable_d;
        end
    end

    assign metering_event = event_q;
    assign cu_enable      = cu_enable_q;
    assign pending_count  = pending_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fczlib_metering_event_gen.sv
// Directed, table-driven bench for fczlib_metering_event_gen
// (NUM_CU=4, CNT_W=4, EVENT_GAP=2). Expectations adapt to FCZLIB_METER_ACT_GATE_EN.
`timescale 1ns/1ps
module tb_fczlib_metering_event_gen;

    localparam int NUM_CU    = 4;
    localparam int CNT_W     = 4;
    localparam int EVENT_GAP = 2;

`ifdef FCZLIB_METER_ACT_GATE_EN
    localparam logic [3:0] ACT_B  = 4'b0101;
    localparam logic [3:0] DONE_B = 4'b1111;
    localparam logic [3:0] EN_B   = 4'b0101;
`else
    localparam logic [3:0] ACT_B  = 4'b0000;
    localparam logic [3:0] DONE_B = 4'b0011;
    localparam logic [3:0] EN_B   = 4'b1111;
`endif
    localparam logic [3:0] ACT_A = 4'b1111;
    localparam logic [3:0] EN_A  = 4'b1111;

    typedef struct {
        logic [3:0] done;
        logic       clr;
        logic [3:0] act;
        logic       exp_ev;
        logic [3:0] exp_pend;
        logic       exp_ovf;
        logic [3:0] exp_en;
    } vec_t;

    logic              clk;
    logic              arstn;
    logic [NUM_CU-1:0] cu_job_done;
    logic [127:0]      activation_code;
    logic              clear_overflow;
    logic              metering_event;
    logic [NUM_CU-1:0] cu_enable;
    logic [CNT_W-1:0]  pending_count;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t va[$];
    vec_t vb[$];

    fczlib_metering_event_gen #(
        .NUM_CU    (NUM_CU),
        .CNT_W     (CNT_W),
        .EVENT_GAP (EVENT_GAP)
    ) dut (
        .ip_core_aclk    (clk),
        .ip_core_arstn   (arstn),
        .cu_job_done     (cu_job_done),
        .activation_code (activation_code),
        .clear_overflow  (clear_overflow),
        .metering_event  (metering_event),
        .cu_enable       (cu_enable),
        .pending_count   (pending_count),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(input logic [3:0] done, input logic clr, input logic [3:0] act,
                                 input logic ev, input logic [3:0] pend, input logic ovf,
                                 input logic [3:0] en);
        vec_t v;
        v.done = done; v.clr = clr; v.act = act;
        v.exp_ev = ev; v.exp_pend = pend; v.exp_ovf = ovf; v.exp_en = en;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [3:0] pend,
                         input logic ovf, input logic [3:0] en);
        n_checks++;
        if (metering_event !== ev || pending_count !== pend || overflow !== ovf || cu_enable !== en) begin
            $display("FAIL %s: got ev=%0b pend=%0d ovf=%0b en=%b, want ev=%0b pend=%0d ovf=%0b en=%b",
                     name, metering_event, pending_count, overflow, cu_enable, ev, pend, ovf, en);
        end else begin
            n_pass++;
            $display("ok   %s: ev=%0b pend=%0d ovf=%0b en=%b",
                     name, metering_event, pending_count, overflow, cu_enable);
        end
    endtask

    // Apply one row for one clock, then compare the registered outputs.
    task automatic run_row(input vec_t v, input string name);
        cu_job_done     = v.done;
        clear_overflow  = v.clr;
        activation_code = {124'd0, v.act};
        @(posedge clk); #1;
        cu_job_done    = '0;
        clear_overflow = 1'b0;
        check(name, v.exp_ev, v.exp_pend, v.exp_ovf, v.exp_en);
    endtask

    initial begin
        // Table A: single job, 4-way burst, saturation and overflow handling.
        va.push_back(row(4'h0, 0, ACT_A, 0, 4'd0,  0, EN_A));
        va.push_back(row(4'h1, 0, ACT_A, 0, 4'd1,  0, EN_A));
        va.push_back(row(4'h0, 0, ACT_A, 1, 4'd0,  0, EN_A));
        for (int i = 0; i < 4; i++) va.push_back(row(4'h0, 0, ACT_A, 0, 4'd0, 0, EN_A));
        va.push_back(row(4'hF, 0, ACT_A, 0, 4'd4,  0, EN_A));
        for (int p = 3; p >= 0; p--) begin
            va.push_back(row(4'h0, 0, ACT_A, 1, 4'(p), 0, EN_A));
            for (int i = 0; i < 3; i++) va.push_back(row(4'h0, 0, ACT_A, 0, 4'(p), 0, EN_A));
        end
        va.push_back(row(4'h0, 0, ACT_A, 0, 4'd0,  0, EN_A));
        va.push_back(row(4'hF, 0, ACT_A, 0, 4'd4,  0, EN_A));
        va.push_back(row(4'hF, 0, ACT_A, 1, 4'd7,  0, EN_A));
        va.push_back(row(4'hF, 0, ACT_A, 0, 4'd11, 0, EN_A));
        va.push_back(row(4'h4, 0, ACT_A, 0, 4'd12, 0, EN_A));
        va.push_back(row(4'h7, 0, ACT_A, 0, 4'd15, 0, EN_A));
        va.push_back(row(4'h1, 0, ACT_A, 1, 4'd15, 0, EN_A));  // max, inc=1 dec=1
        va.push_back(row(4'h1, 0, ACT_A, 0, 4'd15, 1, EN_A));  // drop -> overflow
        va.push_back(row(4'h0, 1, ACT_A, 0, 4'd15, 0, EN_A));  // clear
        va.push_back(row(4'h0, 0, ACT_A, 0, 4'd15, 0, EN_A));
        va.push_back(row(4'h0, 0, ACT_A, 1, 4'd14, 0, EN_A));  // max, inc=0 dec=1
        va.push_back(row(4'hF, 1, ACT_A, 0, 4'd15, 1, EN_A));  // set beats clear
        va.push_back(row(4'h0, 0, ACT_A, 0, 4'd15, 1, EN_A));  // sticky, FSM in GAP

        // Table B: activation gating / forced enables.
        vb.push_back(row(4'h0,   0, ACT_B, 0, 4'd0, 0, EN_B));
        vb.push_back(row(DONE_B, 0, ACT_B, 0, 4'd2, 0, EN_B));
        vb.push_back(row(4'h0,   0, ACT_B, 1, 4'd1, 0, EN_B));
        for (int i = 0; i < 3; i++) vb.push_back(row(4'h0, 0, ACT_B, 0, 4'd1, 0, EN_B));
        vb.push_back(row(4'h0,   0, ACT_B, 1, 4'd0, 0, EN_B));
        for (int i = 0; i < 3; i++) vb.push_back(row(4'h0, 0, ACT_B, 0, 4'd0, 0, EN_B));

        // Power-on reset.
        arstn           = 1'b0;
        cu_job_done     = '0;
        clear_overflow  = 1'b0;
        activation_code = {124'd0, ACT_A};
        #1;
        check("reset_t0", 0, 4'd0, 0, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 0, 4'd0, 0, 4'b0000);
        arstn = 1'b1;
        #1;
        check("release", 0, 4'd0, 0, 4'b0000);

        foreach (va[i]) run_row(va[i], $sformatf("tabA[%0d]", i));

        // Mid-operation reset with a backlog of 15 and the FSM in GAP.
        #3;
        arstn = 1'b0;
        #1;
        check("async_reset", 0, 4'd0, 0, 4'b0000);
        @(posedge clk); #1;
        check("reset_hold", 0, 4'd0, 0, 4'b0000);
        arstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset[%0d]", i), 0, 4'd0, 0, EN_A);
        end

        foreach (vb[i]) run_row(vb[i], $sformatf("tabB[%0d]", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
